// File: rtl/comm_link_scheduler.sv
// Half-duplex line scheduler: arbitrates the shared line between receiver and transmitter,
// with defer, pre/post guard intervals and a TX watchdog. Optional macro: COMM_XTALK_TEST_EN.
module comm_link_scheduler #(
    parameter int unsigned PRE_GUARD    = 20,
    parameter int unsigned POST_GUARD   = 200,
    parameter int unsigned DEFER_MAX    = 4000,
    parameter int unsigned TX_TIMEOUT   = 65535,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned XTALK_PERIOD = 4096
) (
    input  logic             i_inclk,
    input  logic             i_reset,
    input  logic             i_tx_req,
    input  logic             i_rx_decoding,
    input  logic             i_tx_busy,
    output logic             o_rx_on,
    output logic             o_comm_dac_on,
    output logic             o_tx_start,
    output logic             o_tx_abort,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_tx_count,
    output logic [2:0]       o_state,
    output logic             o_xtalk_trig
);

    typedef enum logic [2:0] {
        StRx    = 3'd0,
        StDefer = 3'd1,
        StPre   = 3'd2,
        StTx    = 3'd3,
        StPost  = 3'd4
    } state_e;

    // Zero-valued intervals behave as a single cycle.
    localparam int unsigned PRE_EFF   = (PRE_GUARD == 0) ? 1 : PRE_GUARD;
    localparam int unsigned POST_EFF  = (POST_GUARD == 0) ? 1 : POST_GUARD;
    localparam int unsigned DEFER_EFF = (DEFER_MAX == 0) ? 1 : DEFER_MAX;
    localparam int unsigned TO_EFF    = (TX_TIMEOUT == 0) ? 1 : TX_TIMEOUT;

    localparam logic [15:0] PRE_LAST   = 16'(PRE_EFF - 1);
    localparam logic [15:0] POST_LAST  = 16'(POST_EFF - 1);
    localparam logic [15:0] DEFER_LAST = 16'(DEFER_EFF - 1);
    localparam logic [15:0] TO_LAST    = 16'(TO_EFF - 1);

    if (PRE_GUARD > 65535 || POST_GUARD > 65535 || DEFER_MAX > 65535 ||
        TX_TIMEOUT > 65535) begin : g_bad_param
        $error("comm_link_scheduler: guard/defer/timeout parameter exceeds 16-bit counter");
    end

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_d;
    logic        r_seen_busy;
    logic        w_seen_busy_d;
    logic        w_start;
    logic        w_abort;
    logic        w_done;
    logic        w_burst_start;

    logic             r_rx_on;
    logic             r_dac_on;
    logic             r_tx_start;
    logic             r_tx_abort;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_tx_count;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt + 16'd1;
        w_seen_busy_d = r_seen_busy;
        w_start       = 1'b0;
        w_abort       = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            StRx: begin
                w_cnt_d       = '0;
                w_seen_busy_d = 1'b0;
                if (i_tx_req) begin
                    w_state_d = i_rx_decoding ? StDefer : StPre;
                end
            end
            StDefer: begin
                // Withdrawal outranks both ways into PRE.
                if (!i_tx_req) begin
                    w_state_d = StRx;
                end else if (!i_rx_decoding || (r_cnt == DEFER_LAST)) begin
                    w_state_d = StPre;
                end
            end
            StPre: begin
                w_seen_busy_d = 1'b0;
                if (r_cnt == PRE_LAST) begin
                    w_state_d = StTx;
                    w_start   = 1'b1;
                end
            end
            StTx: begin
                if (i_tx_busy) begin
                    w_seen_busy_d = 1'b1;
                end
                // Normal completion wins over a simultaneous watchdog expiry.
                if (!i_tx_busy && r_seen_busy) begin
                    w_state_d = StPost;
                    w_done    = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_state_d = StPost;
                    w_abort   = 1'b1;
                end
            end
            StPost: begin
                if (r_cnt == POST_LAST) begin
                    w_state_d = StRx;
                end
            end
            default: begin
                w_state_d = StRx;
            end
        endcase
        if (w_state_d != r_state) begin
            w_cnt_d = '0;
        end
    end

    assign w_burst_start = ((r_state == StRx) || (r_state == StDefer)) && (w_state_d == StPre);

    always_ff @(posedge i_inclk) begin
        if (i_reset) begin
            r_state       <= StRx;
            r_cnt         <= '0;
            r_seen_busy   <= 1'b0;
            r_rx_on       <= 1'b1;
            r_dac_on      <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_abort    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tx_count    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_seen_busy   <= w_seen_busy_d;
            r_rx_on       <= (w_state_d == StRx) || (w_state_d == StDefer);
            r_dac_on      <= (w_state_d == StPre) || (w_state_d == StTx);
            r_tx_start    <= w_start;
            r_tx_abort    <= w_abort;
            r_err_timeout <= r_err_timeout | w_abort;
            if (w_done) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
        end
    end

    assign o_rx_on       = r_rx_on;
    assign o_comm_dac_on = r_dac_on;
    assign o_tx_start    = r_tx_start;
    assign o_tx_abort    = r_tx_abort;
    assign o_err_timeout = r_err_timeout;
    assign o_tx_count    = r_tx_count;
    assign o_state       = r_state;

`ifdef COMM_XTALK_TEST_EN
    localparam int unsigned XT_EFF  = (XTALK_PERIOD == 0) ? 1 : XTALK_PERIOD;
    localparam logic [15:0] XT_LAST = 16'(XT_EFF - 1);

    if (XTALK_PERIOD > 65536) begin : g_bad_xtalk
        $error("comm_link_scheduler: XTALK_PERIOD exceeds 16-bit burst counter");
    end

    logic [15:0] r_burst;
    logic        r_xtalk;

    always_ff @(posedge i_inclk) begin
        if (i_reset) begin
            r_burst <= '0;
            r_xtalk <= 1'b0;
        end else begin
            r_xtalk <= 1'b0;
            if (w_burst_start) begin
                if (r_burst == XT_LAST) begin
                    r_burst <= '0;
                    r_xtalk <= 1'b1;
                end else begin
                    r_burst <= r_burst + 16'd1;
                end
            end
        end
    end

    assign o_xtalk_trig = r_xtalk;
`else
    logic w_unused_burst;
    assign w_unused_burst = w_burst_start;
    assign o_xtalk_trig   = 1'b0;
`endif

endmodule

// File: tb/tb_comm_link_scheduler.sv
// Directed self-checking bench for comm_link_scheduler; also covers COMM_XTALK_TEST_EN builds.
module tb_comm_link_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_req;
    logic        rx_decoding;
    logic        tx_busy;
    logic        rx_on;
    logic        dac_on;
    logic        tx_start;
    logic        tx_abort;
    logic        err_timeout;
    logic [15:0] tx_count;
    logic [2:0]  state;
    logic        xtalk_trig;

    int errors = 0;
    int checks = 0;
    int burst_no = 0;
    int xt_cnt = 0;
    int xt_burst[$];
    bit xt_arm = 1'b0;
    bit found;

    comm_link_scheduler #(
        .PRE_GUARD   (20),
        .POST_GUARD  (200),
        .DEFER_MAX   (4000),
        .TX_TIMEOUT  (1000),
        .CNT_W       (16),
        .XTALK_PERIOD(4)
    ) dut (
        .i_inclk      (clk),
        .i_reset      (reset),
        .i_tx_req     (tx_req),
        .i_rx_decoding(rx_decoding),
        .i_tx_busy    (tx_busy),
        .o_rx_on      (rx_on),
        .o_comm_dac_on(dac_on),
        .o_tx_start   (tx_start),
        .o_tx_abort   (tx_abort),
        .o_err_timeout(err_timeout),
        .o_tx_count   (tx_count),
        .o_state      (state),
        .o_xtalk_trig (xtalk_trig)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xt_arm && xtalk_trig === 1'b1) begin
            xt_cnt++;
            xt_burst.push_back(burst_no);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input string tag, input int limit);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            if (state == 3'd0) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic do_burst(input int b);
        burst_no = b;
        tx_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (tx_start) found = 1'b1;
        end
        chk("burst_start", {31'd0, found}, 32'd1);
        tx_req  = 1'b0;
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        wait_rx("burst_rx", 250);
    endtask

    initial begin
        reset       = 1'b1;
        tx_req      = 1'b0;
        rx_decoding = 1'b0;
        tx_busy     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_rx_on", {31'd0, rx_on}, 32'd1);
        chk("rst_dac", {31'd0, dac_on}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_abort", {31'd0, tx_abort}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_count", {16'd0, tx_count}, 32'd0);
        chk("rst_xtalk", {31'd0, xtalk_trig}, 32'd0);

        // Idle-line burst.
        tx_req = 1'b1;
        tick();
        chk("s1_pre_state", {29'd0, state}, 32'd2);
        chk("s1_dac_on", {31'd0, dac_on}, 32'd1);
        chk("s1_rx_off", {31'd0, rx_on}, 32'd0);
        repeat (19) tick();
        chk("s1_start_early", {31'd0, tx_start}, 32'd0);
        chk("s1_still_pre", {29'd0, state}, 32'd2);
        tick();
        chk("s1_start", {31'd0, tx_start}, 32'd1);
        chk("s1_tx_state", {29'd0, state}, 32'd3);
        tx_req  = 1'b0;
        tx_busy = 1'b1;
        tick();
        chk("s1_start_pulse", {31'd0, tx_start}, 32'd0);
        repeat (499) tick();
        chk("s1_tx_dac", {31'd0, dac_on}, 32'd1);
        tx_busy = 1'b0;
        tick();
        chk("s1_post_state", {29'd0, state}, 32'd4);
        chk("s1_dac_off", {31'd0, dac_on}, 32'd0);
        chk("s1_count", {16'd0, tx_count}, 32'd1);
        repeat (199) tick();
        chk("s1_rx_blank", {31'd0, rx_on}, 32'd0);
        tick();
        chk("s1_rx_back", {31'd0, rx_on}, 32'd1);
        chk("s1_rx_state", {29'd0, state}, 32'd0);

        // Defer while decoding, released after 300 cycles.
        rx_decoding = 1'b1;
        tx_req      = 1'b1;
        tick();
        chk("s2_defer", {29'd0, state}, 32'd1);
        repeat (299) tick();
        chk("s2_defer_end", {29'd0, state}, 32'd1);
        chk("s2_rx_on", {31'd0, rx_on}, 32'd1);
        rx_decoding = 1'b0;
        tick();
        chk("s2_pre", {29'd0, state}, 32'd2);
        tx_req = 1'b0;
        repeat (20) tick();
        chk("s2_start", {31'd0, tx_start}, 32'd1);
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        chk("s2_count", {16'd0, tx_count}, 32'd2);
        wait_rx("s2_rx", 250);

        // Stuck decode: pre-empted after DEFER_MAX, then watchdog abort.
        rx_decoding = 1'b1;
        tx_req      = 1'b1;
        tick();
        repeat (3999) tick();
        chk("s3_defer_max", {29'd0, state}, 32'd1);
        tick();
        chk("s3_preempt", {29'd0, state}, 32'd2);
        tx_req      = 1'b0;
        rx_decoding = 1'b0;
        repeat (20) tick();
        chk("s4_start", {31'd0, tx_start}, 32'd1);
        repeat (999) tick();
        chk("s4_no_abort_yet", {31'd0, tx_abort}, 32'd0);
        chk("s4_still_tx", {29'd0, state}, 32'd3);
        tick();
        chk("s4_abort", {31'd0, tx_abort}, 32'd1);
        chk("s4_err", {31'd0, err_timeout}, 32'd1);
        chk("s4_post", {29'd0, state}, 32'd4);
        chk("s4_count", {16'd0, tx_count}, 32'd2);
        tick();
        chk("s4_abort_pulse", {31'd0, tx_abort}, 32'd0);
        chk("s4_err_sticky", {31'd0, err_timeout}, 32'd1);
        wait_rx("s4_rx", 250);

        // Withdrawal at DEFER cycle 50.
        rx_decoding = 1'b1;
        tx_req      = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (dac_on !== 1'b0) found = 1'b1;
        end
        tx_req = 1'b0;
        tick();
        chk("s3b_rx", {29'd0, state}, 32'd0);
        chk("s3b_dac_never", {31'd0, found | dac_on}, 32'd0);
        rx_decoding = 1'b0;

        // Reset mid-TX.
        tx_req = 1'b1;
        repeat (21) tick();
        chk("s5_in_tx", {29'd0, state}, 32'd3);
        tx_req  = 1'b0;
        tx_busy = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("s5_state", {29'd0, state}, 32'd0);
        chk("s5_dac", {31'd0, dac_on}, 32'd0);
        chk("s5_rx_on", {31'd0, rx_on}, 32'd1);
        chk("s5_abort", {31'd0, tx_abort}, 32'd0);
        chk("s5_err", {31'd0, err_timeout}, 32'd0);
        chk("s5_count", {16'd0, tx_count}, 32'd0);
        reset   = 1'b0;
        tx_busy = 1'b0;
        tick();

        // Nine bursts for the cross-talk trigger.
        xt_arm = 1'b1;
        for (int b = 1; b <= 9; b++) begin
            do_burst(b);
        end
        xt_arm = 1'b0;
        chk("xt_bursts", {16'd0, tx_count}, 32'd9);
`ifdef COMM_XTALK_TEST_EN
        chk("xt_pulses", xt_cnt, 32'd2);
        chk("xt_first", (xt_burst.size() > 0) ? xt_burst[0] : -1, 32'd4);
        chk("xt_second", (xt_burst.size() > 1) ? xt_burst[1] : -1, 32'd8);
`else
        chk("xt_off", xt_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
